// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong ball controller: FSM encoding,
// direction constants and default playfield dimensions.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SCORED = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  localparam int GAME_WIDTH    = 40;
  localparam int GAME_HEIGHT   = 30;
  localparam int PADDLE_HEIGHT = 6;
  localparam int P1_PADDLE_X   = 0;
  localparam int P2_PADDLE_X   = 39;
  localparam int BALL_SPEED    = 1250000;

endpackage

// File: rtl/pong_step_timer.sv
// Ball step timer: counts 0..period-1 while enabled and pulses o_Step on the
// terminal count; held at zero while disabled.
module pong_step_timer #(
  parameter int CNT_W = 21
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Enable,
  input  logic [CNT_W-1:0] i_Period,
  output logic             o_Step
);

  logic [CNT_W-1:0] cnt;
  logic             at_end;

  // >= rather than == so a period shortened mid-count still wraps cleanly
  assign at_end = (cnt >= i_Period - CNT_W'(1));
  assign o_Step = i_Enable && at_end;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt <= '0;
    end else if (!i_Enable || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pong_ball_ctrl.sv
// Pong ball controller: serve/run/score FSM, ball motion with wall and paddle
// bounces, registered ball draw. Define PONG_BALL_SPEEDUP_EN to shorten the
// step period on every paddle hit.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int c_GAME_WIDTH    = GAME_WIDTH,
  parameter int c_GAME_HEIGHT   = GAME_HEIGHT,
  parameter int c_PADDLE_HEIGHT = PADDLE_HEIGHT,
  parameter int c_P1_PADDLE_X   = P1_PADDLE_X,
  parameter int c_P2_PADDLE_X   = P2_PADDLE_X,
  parameter int c_BALL_SPEED    = BALL_SPEED
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst_L,
  input  logic                             i_Game_Start,
  input  logic [$clog2(c_GAME_WIDTH)-1:0]  i_Col_Count_Div,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_Row_Count_Div,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_P1_Paddle_Y,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0] i_P2_Paddle_Y,
  output logic                             o_Draw_Ball,
  output logic [$clog2(c_GAME_WIDTH)-1:0]  o_Ball_X,
  output logic [$clog2(c_GAME_HEIGHT)-1:0] o_Ball_Y,
  output logic                             o_P1_Score,
  output logic                             o_P2_Score,
  output logic                             o_Game_Active
);

  localparam int XW    = $clog2(c_GAME_WIDTH);
  localparam int YW    = $clog2(c_GAME_HEIGHT);
  localparam int CNT_W = $clog2(c_BALL_SPEED + 1);

  localparam logic [XW-1:0]    X_CENTER = XW'(c_GAME_WIDTH / 2);
  localparam logic [YW-1:0]    Y_CENTER = YW'(c_GAME_HEIGHT / 2);
  localparam logic [YW-1:0]    Y_MAX    = YW'(c_GAME_HEIGHT - 1);
  localparam logic [XW-1:0]    P1_X     = XW'(c_P1_PADDLE_X);
  localparam logic [XW-1:0]    P1_X1    = XW'(c_P1_PADDLE_X + 1);
  localparam logic [XW-1:0]    P2_X     = XW'(c_P2_PADDLE_X);
  localparam logic [XW-1:0]    P2_XM1   = XW'(c_P2_PADDLE_X - 1);
  localparam logic [YW:0]      PH_M1    = (YW+1)'(c_PADDLE_HEIGHT - 1);
  localparam logic [CNT_W-1:0] PER_MAX  = CNT_W'(c_BALL_SPEED);

  state_t           state, state_nxt;
  logic [XW-1:0]    ball_x, x_nxt;
  logic [YW-1:0]    ball_y, y_nxt;
  logic             x_dir, xd_nxt, y_dir, yd_nxt;
  logic             miss, step;
  logic [CNT_W-1:0] period;

  // One extra bit so top + height - 1 cannot wrap near the bottom edge
  function automatic logic in_paddle(input logic [YW-1:0] top, input logic [YW-1:0] pos);
    logic [YW:0] t, p;
    t = {1'b0, top};
    p = {1'b0, pos};
    return (p >= t) && (p <= t + PH_M1);
  endfunction

  pong_step_timer #(.CNT_W(CNT_W)) u_step_timer (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Enable (state == ST_RUN),
    .i_Period (period),
    .o_Step   (step)
  );

`ifdef PONG_BALL_SPEEDUP_EN
  localparam logic [CNT_W-1:0] PER_DEC = CNT_W'(c_BALL_SPEED / 8);
  localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(c_BALL_SPEED / 2);

  // An X direction flip on a step only happens on a paddle hit
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      period <= PER_MAX;
    end else if (state == ST_IDLE) begin
      period <= PER_MAX;
    end else if (step && (xd_nxt != x_dir)) begin
      period <= (period >= PER_MIN + PER_DEC) ? period - PER_DEC : PER_MIN;
    end
  end
`else
  assign period = PER_MAX;
`endif

  // Next position from the pre-step position and direction of both axes
  always_comb begin
    x_nxt  = ball_x;
    y_nxt  = ball_y;
    xd_nxt = x_dir;
    yd_nxt = y_dir;
    miss   = 1'b0;
    if (y_dir == DIR_UP) begin
      if (ball_y == '0) begin
        yd_nxt = DIR_DOWN;
        y_nxt  = YW'(1);
      end else begin
        y_nxt = ball_y - YW'(1);
      end
    end else if (ball_y == Y_MAX) begin
      yd_nxt = DIR_UP;
      y_nxt  = ball_y - YW'(1);
    end else begin
      y_nxt = ball_y + YW'(1);
    end
    if (x_dir == DIR_LEFT) begin
      if (ball_x == P1_X) begin
        miss = 1'b1;
      end else if (ball_x == P1_X1 && in_paddle(i_P1_Paddle_Y, ball_y)) begin
        xd_nxt = DIR_RIGHT;
        x_nxt  = ball_x + XW'(1);
      end else begin
        x_nxt = ball_x - XW'(1);
      end
    end else begin
      if (ball_x == P2_X) begin
        miss = 1'b1;
      end else if (ball_x == P2_XM1 && in_paddle(i_P2_Paddle_Y, ball_y)) begin
        xd_nxt = DIR_LEFT;
        x_nxt  = ball_x - XW'(1);
      end else begin
        x_nxt = ball_x + XW'(1);
      end
    end
    // A miss freezes the ball; the kept X direction already points at the
    // conceding player, which is where the next serve goes
    if (miss) begin
      x_nxt  = ball_x;
      y_nxt  = ball_y;
      yd_nxt = y_dir;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_Game_Start) state_nxt = ST_RUN;
      ST_RUN:    if (step && miss) state_nxt = ST_SCORED;
      ST_SCORED: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_Game_Active = (state == ST_RUN);
    o_P2_Score    = (state == ST_SCORED) && (x_dir == DIR_LEFT);
    o_P1_Score    = (state == ST_SCORED) && (x_dir == DIR_RIGHT);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ball_x <= X_CENTER;
      ball_y <= Y_CENTER;
      x_dir  <= DIR_RIGHT;
      y_dir  <= DIR_DOWN;
    end else if (state != ST_RUN) begin
      ball_x <= X_CENTER;
      ball_y <= Y_CENTER;
    end else if (step) begin
      ball_x <= x_nxt;
      ball_y <= y_nxt;
      x_dir  <= xd_nxt;
      y_dir  <= yd_nxt;
    end
  end

  // Draw stage: one register between scan position and o_Draw_Ball
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Draw_Ball <= 1'b0;
    end else begin
      o_Draw_Ball <= (i_Col_Count_Div == ball_x) && (i_Row_Count_Div == ball_y);
    end
  end

  assign o_Ball_X = ball_x;
  assign o_Ball_Y = ball_y;

endmodule
